// File: rtl/rv_pkg.sv
// Shared types and constants for the multicycle RISC-V core's memory subsystem.
package rv_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam int MEM_WORDS = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick between the fetch and data ports.
module rr_arb2
  import rv_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last,
  output grant_t grant
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant = GRANT_I;
    if (req_i && req_d) begin
      grant = (last == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port word memory between fetch and load/store with a
// req/ack handshake, round-robin on contention and a fixed 3-cycle access.
module mem_arbiter
  import rv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t        state;
  arb_state_t        next_state;
  grant_t            grant;
  grant_t            last_grant;
  grant_t            pick;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              store_q;
  logic              elig_i;
  logic              elig_d;
  logic              start;

  // A port whose ack is high is finishing right now and must not be re-granted.
  assign elig_i = i_req && !i_ack;
  assign elig_d = d_req && !d_ack;

  rr_arb2 u_rr (
    .req_i (elig_i),
    .req_d (elig_d),
    .last  (last_grant),
    .grant (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = '0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (elig_i || elig_d) begin
          start      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        if (grant == GRANT_D && store_q) begin
          mem_we = wstrb_q;
        end
        next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Request fields are captured at grant so requesters may change them after ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= GRANT_I;
      last_grant <= GRANT_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      store_q    <= 1'b0;
    end else begin
      if (start) begin
        grant <= pick;
        if (pick == GRANT_D) begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          wstrb_q <= d_wstrb;
          store_q <= d_we;
        end else begin
          addr_q  <= i_addr;
          store_q <= 1'b0;
        end
      end
      if (state == RESP) begin
        last_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (state == RESP) begin
        if (grant == GRANT_I) begin
          i_rdata <= mem_rdata;
          i_ack   <= 1'b1;
        end else begin
          d_ack <= 1'b1;
          if (!store_q) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, word-level reference
// model and directed plus randomized accesses on both ports.
module tb_mem_arbiter;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [9:0]  i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int checks   = 0;
  int failures = 0;
  bit last_d;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: synchronous read one cycle after mem_en, byte-masked write.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = v;
    ref_mem[a] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One access on one port with the other port idle; checks the memory-side
  // cycle shape, the 3-cycle latency and the returned data against the model.
  task automatic single_access(input string tag, input bit is_d, input bit we,
                               input logic [9:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int          lat;
    bit          other_ack;
    logic [31:0] prev_d;
    logic [3:0]  exp_we;
    @(negedge clk);
    prev_d = d_rdata;
    exp_we = (is_d && we) ? ws : 4'h0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    lat = 0;
    other_ack = 1'b0;
    while (lat < 10 && !(is_d ? d_ack : i_ack)) begin
      @(negedge clk);
      lat++;
      if (is_d ? i_ack : d_ack) other_ack = 1'b1;
      if (lat == 1) begin
        check_output({tag, "_issue_en"}, 32'(mem_en), 32'd1);
        check_output({tag, "_issue_addr"}, 32'(mem_addr), 32'(a));
        check_output({tag, "_issue_we"}, 32'(mem_we), 32'(exp_we));
      end
      if (lat == 2) begin
        check_output({tag, "_resp_en"}, 32'(mem_en), 32'd0);
        check_output({tag, "_resp_we"}, 32'(mem_we), 32'd0);
      end
    end
    check_output({tag, "_latency"}, lat, 32'd3);
    check_output({tag, "_other_ack"}, 32'(other_ack), 32'd0);
    if (is_d && we) begin
      ref_mem[a] = merge(ref_mem[a], wd, ws);
      check_output({tag, "_rdata_hold"}, d_rdata, prev_d);
    end else if (is_d) begin
      check_output({tag, "_d_rdata"}, d_rdata, ref_mem[a]);
    end else begin
      check_output({tag, "_i_rdata"}, i_rdata, ref_mem[a]);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    last_d = is_d;
  endtask

  // Both ports request in the same cycle; the model picks the winner from the
  // port granted last and serialises the memory effects in that order.
  task automatic tie_pair(input string tag, input logic [9:0] ia, input bit dwe,
                          input logic [9:0] da, input logic [31:0] wd, input logic [3:0] ws);
    bit          first_d;
    int          t_i;
    int          t_d;
    int          n;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    logic [31:0] obs_i;
    logic [31:0] obs_d;
    @(negedge clk);
    first_d = !last_d;
    exp_d = d_rdata;
    if (first_d) begin
      if (dwe) ref_mem[da] = merge(ref_mem[da], wd, ws);
      else exp_d = ref_mem[da];
      exp_i = ref_mem[ia];
    end else begin
      exp_i = ref_mem[ia];
      if (dwe) ref_mem[da] = merge(ref_mem[da], wd, ws);
      else exp_d = ref_mem[da];
    end
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_we = dwe; d_addr = da; d_wdata = wd; d_wstrb = ws;
    t_i = 0; t_d = 0; n = 0;
    obs_i = 32'h0; obs_d = 32'h0;
    while (n < 12 && (t_i == 0 || t_d == 0)) begin
      @(negedge clk);
      n++;
      if (i_ack && t_i == 0) begin t_i = n; obs_i = i_rdata; i_req = 1'b0; end
      if (d_ack && t_d == 0) begin t_d = n; obs_d = d_rdata; d_req = 1'b0; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check_output({tag, "_winner_ack"}, first_d ? t_d : t_i, 32'd3);
    check_output({tag, "_loser_ack"}, first_d ? t_i : t_d, 32'd6);
    check_output({tag, "_i_rdata"}, obs_i, exp_i);
    check_output({tag, "_d_rdata"}, obs_d, exp_d);
    last_d = !first_d;
  endtask

  initial begin
    int          n_acks;
    bit          exp_port_d;
    logic [31:0] v;

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    last_d = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_i_ack", 32'(i_ack), 32'd0);
    check_output("rst_d_ack", 32'(d_ack), 32'd0);
    check_output("rst_i_rdata", i_rdata, 32'd0);
    check_output("rst_d_rdata", d_rdata, 32'd0);
    check_output("rst_mem_en", 32'(mem_en), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) preload(10'(a), $urandom);
    preload(10'd5, 32'h0001F0B7);
    preload(10'd3, 32'hFFFFFFFF);

    $display("[TB] tie after reset");
    tie_pair("tie_reset", 10'd1, 1'b0, 10'd2, 32'h0, 4'h0);

    $display("[TB] single fetch");
    single_access("fetch5", 1'b0, 1'b0, 10'd5, 32'h0, 4'h0);
    check_output("fetch5_value", i_rdata, 32'h0001F0B7);

    $display("[TB] store then load");
    single_access("store0", 1'b1, 1'b1, 10'd0, 32'h0001F000, 4'hF);
    single_access("load0", 1'b1, 1'b0, 10'd0, 32'h0, 4'h0);
    check_output("load0_value", d_rdata, 32'h0001F000);

    $display("[TB] partial store");
    single_access("pstore3", 1'b1, 1'b1, 10'd3, 32'h12345678, 4'b0011);
    single_access("pload3", 1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
    check_output("pload3_value", d_rdata, 32'hFFFF5678);

    $display("[TB] tie after a fetch");
    single_access("fetch4", 1'b0, 1'b0, 10'd4, 32'h0, 4'h0);
    tie_pair("tie_data_wins", 10'd6, 1'b0, 10'd9, 32'h0, 4'h0);

    $display("[TB] reset mid-op");
    @(negedge clk);
    i_req = 1'b1; i_addr = 10'd1;
    @(negedge clk);
    check_output("midrst_issue_en", 32'(mem_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_mem_en", 32'(mem_en), 32'd0);
    check_output("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("midrst_i_rdata", i_rdata, 32'd0);
    check_output("midrst_d_rdata", d_rdata, 32'd0);
    i_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("midrst_no_ack", 32'(i_ack), 32'd0);
    end
    rst_n = 1'b1;
    last_d = 1'b1;
    single_access("refetch1", 1'b0, 1'b0, 10'd1, 32'h0, 4'h0);

    $display("[TB] saturation");
    @(negedge clk);
    i_req = 1'b1; i_addr = 10'd7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd8;
    n_acks = 0;
    exp_port_d = !last_d;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        n_acks++;
        check_output("sat_order", 32'({i_ack, d_ack}), exp_port_d ? 32'd1 : 32'd2);
        if (i_ack) check_output("sat_i_rdata", i_rdata, ref_mem[7]);
        else       check_output("sat_d_rdata", d_rdata, ref_mem[8]);
        exp_port_d = !exp_port_d;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check_output("sat_ack_count", n_acks, 32'd20);
    last_d = !exp_port_d;

    $display("[TB] random traffic");
    for (int k = 0; k < 24; k++) begin
      int          mode;
      logic [9:0]  ra;
      logic [9:0]  rb;
      logic [31:0] rw;
      logic [3:0]  rs;
      mode = int'($urandom_range(0, 3));
      ra = 10'($urandom_range(0, 15));
      rb = 10'($urandom_range(0, 15));
      rw = $urandom;
      rs = 4'($urandom);
      case (mode)
        0: single_access("rnd_fetch", 1'b0, 1'b0, ra, 32'h0, 4'h0);
        1: single_access("rnd_load", 1'b1, 1'b0, ra, 32'h0, 4'h0);
        2: single_access("rnd_store", 1'b1, 1'b1, ra, rw, rs);
        default: tie_pair("rnd_tie", ra, 1'($urandom_range(0, 1)), rb, rw, rs);
      endcase
    end
    for (int a = 0; a < 16; a++) begin
      single_access("final_read", 1'b1, 1'b0, 10'(a), 32'h0, 4'h0);
    end

    v = 32'h0;
    repeat (5) begin
      @(negedge clk);
      v = v | 32'({i_ack, d_ack, mem_en});
    end
    check_output("idle_quiet", v, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
